// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and bus-side signals of the UART receive FIFO.
// almost_full exists only when UART_RX_FIFO_ALMOST_FULL_EN is defined.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          clr_rdy;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          ovr_clr;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  // master: the receiver and the bus reader driving the FIFO
  modport master (
    output rx_rdy, rx_data, rd_en, ovr_clr,
    input  clr_rdy, rd_data, empty, full, count, overrun
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    , input almost_full
`endif
  );

  // slave: the FIFO itself
  modport slave (
    input  rx_rdy, rx_data, rd_en, ovr_clr,
    output clr_rdy, rd_data, empty, full, count, overrun
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    , output almost_full
`endif
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures one byte per rx_rdy assertion, FWFT read port, sticky overrun.
// Optional almost_full output under UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of 2, at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: AF_THRESH must be in 1..DEPTH");
  end

  logic [0:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overrun;
  logic [7:0]    mem [DEPTH];

  logic is_empty;
  logic is_full;
  logic push_req;
  logic pop;
  logic push;
  logic drop;

  // A full FIFO still accepts a push when the same edge frees a slot.
  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == CW'(DEPTH));
    push_req = (state == ST_WAIT) && bus.rx_rdy;
    pop      = bus.rd_en && !is_empty;
    push     = push_req && (!is_full || pop);
    drop     = push_req && is_full && !pop;
  end

  // ACK holds clr_rdy until the receiver lets rx_rdy fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
    end else begin
      case (state)
        ST_WAIT: if (bus.rx_rdy)  state <= ST_ACK;
        ST_ACK:  if (!bus.rx_rdy) state <= ST_WAIT;
        default: state <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)             overrun <= 1'b1;
      else if (bus.ovr_clr) overrun <= 1'b0;
    end
  end

  // Storage is data only and deliberately carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  assign bus.clr_rdy = (state == ST_ACK);
  assign bus.rd_data = mem[rd_ptr];
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.count   = count;
  assign bus.overrun = overrun;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  assign bus.almost_full = (count >= CW'(AF_THRESH));
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized + directed bench for uart_rx_fifo with a queue-based reference model and negedge monitor.
module tb_uart_rx_fifo;
  localparam int DEPTH     = 8;
  localparam int AF_THRESH = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bif ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: expected FIFO contents, sticky overrun, last sampled rx_rdy.
  logic [7:0] exp_q[$];
  logic       m_ovr;
  logic       m_prev_rx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One push attempt per rising rx_rdy; clr_rdy is rx_rdy delayed one clock.
  always @(posedge clk or negedge rst_n) begin
    int  sz;
    bit  do_pop;
    bit  attempt;
    if (!rst_n) begin
      exp_q.delete();
      m_ovr     = 1'b0;
      m_prev_rx = 1'b0;
    end else begin
      sz      = exp_q.size();
      do_pop  = bif.rd_en && (sz > 0);
      attempt = bif.rx_rdy && !m_prev_rx;
      if (do_pop) void'(exp_q.pop_front());
      if (attempt) begin
        if (sz < DEPTH || do_pop) exp_q.push_back(bif.rx_data);
        else                      m_ovr = 1'b1;
      end
      if (!(attempt && sz == DEPTH && !do_pop) && bif.ovr_clr) m_ovr = 1'b0;
      m_prev_rx = bif.rx_rdy;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("count",   bif.count,   exp_q.size());
      chk("empty",   bif.empty,   exp_q.size() == 0);
      chk("full",    bif.full,    exp_q.size() == DEPTH);
      chk("overrun", bif.overrun, m_ovr);
      chk("clr_rdy", bif.clr_rdy, m_prev_rx);
      if (exp_q.size() > 0) chk("rd_data", bif.rd_data, exp_q[0]);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      chk("almost_full", bif.almost_full, exp_q.size() >= AF_THRESH);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check();
    chk("rst_count",   bif.count,   0);
    chk("rst_empty",   bif.empty,   1);
    chk("rst_full",    bif.full,    0);
    chk("rst_overrun", bif.overrun, 0);
    chk("rst_clr_rdy", bif.clr_rdy, 0);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    chk("rst_almost_full", bif.almost_full, 0);
`endif
  endtask

  // Reset asserted between clock edges; outputs must return at once.
  task automatic do_reset();
    bif.rx_rdy  = 1'b0;
    bif.rd_en   = 1'b0;
    bif.ovr_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_check();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send(input logic [7:0] b);
    bif.rx_data = b;
    bif.rx_rdy  = 1'b1;
    step();
    chk("ack_after_push", bif.clr_rdy, 1);
    bif.rx_rdy = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] first_pop;
    logic [7:0] last_pop;
    bif.rx_rdy  = 1'b0;
    bif.rx_data = 8'h00;
    bif.rd_en   = 1'b0;
    bif.ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_check();
    rst_n = 1'b1;
    step();

    // Single byte capture
    send(8'hA5);
    chk("t1_count", bif.count, 1);
    chk("t1_empty", bif.empty, 0);
    chk("t1_rd_data", bif.rd_data, 8'hA5);

    // rx_rdy held for 20 cycles: only one push
    do_reset();
    bif.rx_data = 8'h5A;
    bif.rx_rdy  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_clr_rdy", bif.clr_rdy, 1);
      chk("hold_count", bif.count, 1);
    end
    bif.rx_rdy = 1'b0;
    step();
    step();
    chk("hold_release_clr", bif.clr_rdy, 0);
    chk("hold_final_count", bif.count, 1);

    // Fill to full
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'(i));
    chk("fill_full", bif.full, 1);
    chk("fill_count", bif.count, DEPTH);

    // Drop while full, then clear
    send(8'hFF);
    chk("drop_overrun", bif.overrun, 1);
    chk("drop_count", bif.count, DEPTH);
    chk("drop_head", bif.rd_data, 8'h00);
    bif.ovr_clr = 1'b1;
    step();
    bif.ovr_clr = 1'b0;
    chk("ovr_cleared", bif.overrun, 0);

    // Drop and clear in the same cycle: set wins
    bif.rx_data = 8'hEE;
    bif.rx_rdy  = 1'b1;
    bif.ovr_clr = 1'b1;
    step();
    bif.ovr_clr = 1'b0;
    bif.rx_rdy  = 1'b0;
    chk("set_wins", bif.overrun, 1);
    step();
    bif.ovr_clr = 1'b1;
    step();
    bif.ovr_clr = 1'b0;

    // Push with same-cycle pop while full
    bif.rx_data = 8'h3C;
    bif.rx_rdy  = 1'b1;
    bif.rd_en   = 1'b1;
    step();
    bif.rd_en  = 1'b0;
    bif.rx_rdy = 1'b0;
    chk("fullpop_count", bif.count, DEPTH);
    chk("fullpop_overrun", bif.overrun, 0);
    step();
    first_pop = 8'h00;
    last_pop  = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) first_pop = bif.rd_data;
      last_pop  = bif.rd_data;
      bif.rd_en = 1'b1;
      step();
    end
    chk("drain_first", first_pop, 8'h01);
    chk("drain_last_wrap", last_pop, 8'h3C);
    chk("drain_empty", bif.empty, 1);
    step();
    bif.rd_en = 1'b0;
    chk("extra_pop_count", bif.count, 0);

    // Push into empty FIFO with same-cycle pop: pop ignored
    bif.rx_data = 8'h77;
    bif.rx_rdy  = 1'b1;
    bif.rd_en   = 1'b1;
    step();
    bif.rd_en  = 1'b0;
    bif.rx_rdy = 1'b0;
    chk("emptypop_count", bif.count, 1);
    chk("emptypop_data", bif.rd_data, 8'h77);
    step();

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
    chk("af_at_5", bif.almost_full, 0);
    send(8'h15);
    chk("af_at_6", bif.almost_full, 1);
`else
    do_reset();
    for (int i = 0; i < 3; i++) send(8'(8'h10 + i));
`endif
    // Reset mid-fill
    do_reset();

    // Randomized traffic: a filling phase then a draining phase
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 250; c++) begin
        bif.rd_en   = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        bif.ovr_clr = ($urandom_range(0, 15) == 0);
        if (!bif.rx_rdy) begin
          if ($urandom_range(0, 1) == 1) begin
            bif.rx_rdy  = 1'b1;
            bif.rx_data = 8'($urandom);
          end
        end else if (bif.clr_rdy && $urandom_range(0, 2) == 0) begin
          bif.rx_rdy = 1'b0;
        end
        step();
      end
    end
    bif.rx_rdy  = 1'b0;
    bif.rd_en   = 1'b0;
    bif.ovr_clr = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It watches the receiver's rdy/rx_data pair, captures each completed byte into a circular FIFO and drives clr_rdy back to knock down rdy. A processor/bus side drains bytes through a first-word-fall-through read port. Full and empty status are reported, and dropped bytes are flagged with a sticky overrun bit.

Parameters:
DEPTH, 8, number of byte entries; must be a power of 2, minimum 2.
AF_THRESH, 6, almost_full threshold; used only when the optional feature is compiled in; range 1..DEPTH.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  receiver byte-ready; level, held high until cleared
rx_data  input  8  received byte; valid while rx_rdy=1
clr_rdy  output  1  acknowledge to receiver; knocks down rx_rdy
rd_en  input  1  pop request from bus side
rd_data  output  8  head-of-FIFO byte; valid when empty=0
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: a byte was dropped because the FIFO was full
ovr_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n=0, asynchronous): write/read pointers=0, count=0, empty=1, full=0, overrun=0, clr_rdy=0, capture FSM=WAIT. FIFO storage is not reset.
- Capture FSM, two states:
  - WAIT: when rx_rdy=1, push rx_data at that clock edge (subject to the full rules below) and go to ACK.
  - ACK: clr_rdy=1 (Moore output, registered state). Leave for WAIT in the first cycle rx_rdy is sampled 0. Otherwise stay.
  - clr_rdy is 0 in WAIT.
  - Result: exactly one push per rx_rdy assertion, regardless of how long rx_rdy stays high.
- Push timing:
  - Byte is written at the edge ending the first WAIT cycle with rx_rdy=1.
  - count/empty reflect the push on the following cycle.
  - Push latency to rd_data: 1 clock.
- Pop:
  - rd_en=1 with empty=0 advances the read pointer at the clock edge.
  - rd_data is combinational from the head entry (first-word fall-through).
  - rd_en with empty=1 is ignored: no pointer change, no error.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, a push with a same-cycle pop is accepted: no drop, no overrun.
  - When empty, a push with a same-cycle pop: the pop is ignored and the push proceeds.
- Full without pop:
  - The push is dropped and FIFO contents are unchanged.
  - overrun is set on the next edge.
  - The FSM still goes to ACK and clears the receiver.
- overrun:
  - Set by a drop, cleared by ovr_clr=1.
  - If a drop and ovr_clr occur in the same cycle, set wins (overrun=1).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is maintained as a separate up/down counter. empty=(count==0), full=(count==DEPTH), both registered-consistent with count.
- rx_rdy falling on its own while in ACK (the receiver cleared rdy on a new start bit): the FSM returns to WAIT normally.

Optional Feature:
Macro UART_RX_FIFO_ALMOST_FULL_EN.
- Defined: adds output port almost_full (1 bit) = (count >= AF_THRESH), reset value 0, same timing as count.
- Undefined: no almost_full port and no related logic; AF_THRESH is unused. All other behaviour is identical.

Test Plan:
- Reset, then apply rx_rdy=1 with rx_data=8'hA5 until clr_rdy is seen -> clr_rdy pulses; exactly 1 entry pushed; count=1; empty=0; rd_data=8'hA5.
- Hold rx_rdy=1 for 20 cycles without it clearing -> only one push; clr_rdy stays 1 throughout; count=1.
- Push 8'h00..8'h07 into DEPTH=8, then pop 8 times -> full=1 after the 8th push; rd_data sequence 00..07; empty=1 after the last pop; extra rd_en leaves count=0.
- With the FIFO full, push 8'hFF -> byte dropped; overrun=1; count=8; head still 8'h00. Then ovr_clr=1 -> overrun=0. Repeat with drop and ovr_clr in the same cycle -> overrun=1.
- With the FIFO full, push 8'h3C while rd_en=1 in the same cycle -> count stays 8; overrun=0; the last entry read out is 8'h3C (pointer wrap verified).
- With UART_RX_FIFO_ALMOST_FULL_EN and AF_THRESH=6 -> almost_full=0 at count 5, 1 at count 6; assert rst_n=0 mid-fill -> all outputs return to their reset values immediately.
